// File: rtl/mbz_nxm_err_ctl.sv
// Watchdog and error capture for the MBZ core reference path: times each SBUS
// reference, forges the NXM ack/data sequence on timeout, and holds the first error address.
module mbz_nxm_err_ctl #(
  parameter int NSRC      = 4,
  parameter int ADR_W     = 22,
  parameter int TMO_W     = 8,
  parameter int NXM_STEPS = 5,
  localparam int SRC_W    = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 MEM_START,
  input  logic [SRC_W-1:0]     RQ_SRC,
  input  logic [ADR_W-1:0]     RQ_ADR,
  input  logic                 RQ_RD,
  input  logic                 RQ_WR,
  input  logic                 ACKN_PULSE,
  input  logic                 DATA_VAL,
  input  logic                 MB_PAR_ODD,
  input  logic                 ADR_PAR_ERR,
  input  logic [TMO_W-1:0]     TMO_LIMIT,
  input  logic [NSRC-1:0]      ERR_CLR,
  input  logic                 ERA_CLR,
  output logic                 CORE_BUSY,
  output logic [NXM_STEPS-1:0] NXM_T,
  output logic                 NXM_ACK,
  output logic                 NXM_DATA_VAL,
  output logic                 LOAD_MB_MAGIC,
  output logic [NSRC-1:0]      NXM_ERR,
  output logic [NSRC-1:0]      PAR_ERR,
  output logic [NSRC-1:0]      APE_ERR,
  output logic [ADR_W-1:0]     ERA,
  output logic [SRC_W-1:0]     ERA_SRC,
  output logic                 ERA_WR,
  output logic                 ERA_VALID,
  output logic                 RQ_OVERRUN
);

  typedef enum logic [1:0] {IDLE, WAIT, NXM, RPW} state_t;

  state_t               state_q, state_d;
  logic [TMO_W-1:0]     cnt_q, cnt_d, lim_q;
  logic [NXM_STEPS-1:0] step_q, step_d;
  logic                 acked_q, acked_d;
  logic                 own_q;
  logic [SRC_W-1:0]     src_q;
  logic [ADR_W-1:0]     adr_q;
  logic                 rd_q, wr_q;
  logic                 tmo, in_ref, par_hit, ape_hit, err_any;
  logic [NSRC-1:0]      src_oh;

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] c);
    return (c == {TMO_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // T2 is the timeout-compare cycle itself, so it is decoded combinationally
  // and an ACKN arriving in that same cycle cancels it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    acked_d = acked_q;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_START) begin
          state_d = WAIT;
          cnt_d   = '0;
          acked_d = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = sat_inc(cnt_q);
        if (ACKN_PULSE && !acked_q) begin
          cnt_d = '0;
          if (rd_q && wr_q) begin
            state_d = RPW;
          end else if (rd_q) begin
            acked_d = 1'b1;
            if (DATA_VAL) state_d = IDLE;
          end else begin
            state_d = IDLE;
          end
        end else if (acked_q && DATA_VAL) begin
          state_d = IDLE;
        end else if (cnt_q == lim_q) begin
          tmo = 1'b1;
        end
      end
      RPW: begin
        cnt_d = sat_inc(cnt_q);
        if (ACKN_PULSE)           state_d = IDLE;
        else if (cnt_q == lim_q)  tmo = 1'b1;
      end
      NXM: begin
        step_d = step_q << 1;
        if (step_q[NXM_STEPS-1]) begin
          state_d = IDLE;
          step_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d = NXM;
      step_d  = NXM_STEPS'(2);
    end
  end

  assign in_ref        = (state_q == WAIT) || (state_q == RPW);
  assign par_hit       = in_ref && rd_q && DATA_VAL && !MB_PAR_ODD;
  assign ape_hit       = in_ref && ADR_PAR_ERR;
  assign err_any       = tmo || par_hit || ape_hit;
  assign src_oh        = NSRC'(1) << src_q;
  assign CORE_BUSY     = (state_q != IDLE);
  assign NXM_T         = step_q | NXM_STEPS'(tmo);
  assign NXM_ACK       = tmo;
  assign NXM_DATA_VAL  = step_q[NXM_STEPS-1] && rd_q;
  // Magic is suppressed only when ERA was captured by an earlier reference.
  assign LOAD_MB_MAGIC = (NXM_DATA_VAL || par_hit) && !(ERA_VALID && !own_q);

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      step_q     <= '0;
      acked_q    <= 1'b0;
      own_q      <= 1'b0;
      NXM_ERR    <= '0;
      PAR_ERR    <= '0;
      APE_ERR    <= '0;
      ERA        <= '0;
      ERA_SRC    <= '0;
      ERA_WR     <= 1'b0;
      ERA_VALID  <= 1'b0;
      RQ_OVERRUN <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      acked_q <= acked_d;
      NXM_ERR <= (NXM_ERR & ~ERR_CLR) | (tmo     ? src_oh : '0);
      PAR_ERR <= (PAR_ERR & ~ERR_CLR) | (par_hit ? src_oh : '0);
      APE_ERR <= (APE_ERR & ~ERR_CLR) | (ape_hit ? src_oh : '0);
      if (MEM_START && state_q != IDLE) RQ_OVERRUN <= 1'b1;
      if (state_q == IDLE && MEM_START) own_q <= 1'b0;
      if (err_any && (!ERA_VALID || ERA_CLR)) begin
        ERA       <= adr_q;
        ERA_SRC   <= src_q;
        ERA_WR    <= wr_q;
        ERA_VALID <= 1'b1;
        own_q     <= 1'b1;
      end else if (ERA_CLR) begin
        ERA_VALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && MEM_START) begin
      src_q <= RQ_SRC;
      adr_q <= RQ_ADR;
      rd_q  <= RQ_RD;
      wr_q  <= RQ_WR;
      lim_q <= (TMO_LIMIT == '0) ? {TMO_W{1'b1}} : TMO_LIMIT;
    end
  end

endmodule
